// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity and tick-divisor helpers
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } par_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Data is zero-padded to this width so one helper serves every FRAME_WD.
  localparam int PAR_IN_W = 16;

  function automatic logic par(input logic [PAR_IN_W-1:0] data, input par_mode_e mode);
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

  function automatic int os_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// rtl/uart_os_tick.sv - divide-by-DIV tick generator with synchronous clear
module uart_os_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - 16x oversampling UART receiver with valid/ready frame output
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int    CLK_FREQUENCE = 50_000_000,
  parameter int    BAUD_RATE     = 115200,
  parameter string PARITY        = "EVEN",
  parameter int    FRAME_WD      = 8,
  parameter int    OVERSAMPLE    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uart_rx,
  input  logic                rx_ready,
  output logic [FRAME_WD-1:0] rx_frame,
  output logic                rx_valid,
  output logic                rx_done,
  output logic                parity_error,
  output logic                frame_error,
  output logic                overrun
);

  localparam par_mode_e MODE = (PARITY == "NONE") ? PAR_NONE :
                               ((PARITY == "ODD") ? PAR_ODD : PAR_EVEN);
  localparam int OS_DIV = os_div(CLK_FREQUENCE, BAUD_RATE, OVERSAMPLE);
  localparam int S_W    = $clog2(OVERSAMPLE);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_M0   = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_M1   = S_W'(OVERSAMPLE / 2);
  localparam logic [S_W-1:0] S_M2   = S_W'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]     IDX_LAST = 4'(FRAME_WD - 1);

  logic sync1_q, sync1_d, rxs_q, rxs_d, rxs_prev_q, rxs_prev_d;

  rx_state_e state_q, state_d;

  logic [S_W-1:0]      s_q, s_d;
  logic [3:0]          idx_q, idx_d;
  logic [2:0]          samp_q, samp_d;
  logic [FRAME_WD-1:0] shreg_q, shreg_d;
  logic                perr_q, perr_d;
  logic                fresh_q, fresh_d;
  logic [FRAME_WD-1:0] rx_frame_q, rx_frame_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rx_done_q, rx_done_d;
  logic                parity_error_q, parity_error_d;
  logic                frame_error_q, frame_error_d;
  logic                overrun_q, overrun_d;

  logic                os_tick;
  logic                tick_clr;
  logic                maj_bit;
  logic                stop_maj;
  logic                bit_end;
  logic                stop_hit;
  logic                start_det;
  logic [PAR_IN_W-1:0] par_in;

  uart_os_tick #(
    .DIV(OS_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (tick_clr),
    .tick(os_tick)
  );

  always_comb begin
    sync1_d    = uart_rx;
    rxs_d      = sync1_q;
    rxs_prev_d = rxs_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= sync1_d;
      rxs_q      <= rxs_d;
      rxs_prev_q <= rxs_prev_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_det) state_d = ST_START;
      ST_START:  if (bit_end) state_d = maj_bit ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_end && (idx_q == IDX_LAST)) begin
                   state_d = (MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
                 end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP:   if (stop_hit) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // A clean stop lets IDLE take an already-low line as the next start;
  // after a break the line must go high and fall again.
  always_comb begin
    tick_clr  = (state_q == ST_IDLE);
    maj_bit   = maj3(samp_q[0], samp_q[1], samp_q[2]);
    stop_maj  = maj3(samp_q[0], samp_q[1], rxs_q);
    bit_end   = os_tick && (s_q == S_LAST);
    stop_hit  = os_tick && (s_q == S_M2) && (state_q == ST_STOP);
    start_det = (state_q == ST_IDLE) && !rxs_q && (rxs_prev_q || fresh_q);
  end

  always_comb begin
    par_in                 = '0;
    par_in[FRAME_WD-1:0]   = shreg_q;
  end

  always_comb begin
    s_d            = s_q;
    idx_d          = idx_q;
    samp_d         = samp_q;
    shreg_d        = shreg_q;
    perr_d         = perr_q;
    fresh_d        = fresh_q;
    rx_frame_d     = rx_frame_q;
    rx_valid_d     = rx_valid_q && !rx_ready;
    rx_done_d      = 1'b0;
    parity_error_d = parity_error_q;
    frame_error_d  = frame_error_q;
    overrun_d      = 1'b0;

    if (state_q == ST_IDLE) begin
      s_d     = '0;
      idx_d   = '0;
      perr_d  = 1'b0;
      fresh_d = 1'b0;
    end

    if (os_tick) begin
      s_d = (s_q == S_LAST) ? '0 : s_q + S_W'(1);
      if (s_q == S_M0) samp_d[0] = rxs_q;
      if (s_q == S_M1) samp_d[1] = rxs_q;
      if (s_q == S_M2) samp_d[2] = rxs_q;
    end

    if (bit_end && (state_q == ST_DATA)) begin
      shreg_d = {maj_bit, shreg_q[FRAME_WD-1:1]};
      idx_d   = idx_q + 4'd1;
    end

    if (bit_end && (state_q == ST_PARITY)) begin
      perr_d = (maj_bit != par(par_in, MODE));
    end

    if (stop_hit) begin
      rx_done_d      = 1'b1;
      parity_error_d = perr_q;
      frame_error_d  = !stop_maj;
      fresh_d        = stop_maj;
      if (!rx_valid_q || rx_ready) begin
        rx_frame_d = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q            <= '0;
      idx_q          <= '0;
      samp_q         <= '0;
      shreg_q        <= '0;
      perr_q         <= 1'b0;
      fresh_q        <= 1'b0;
      rx_frame_q     <= '0;
      rx_valid_q     <= 1'b0;
      rx_done_q      <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      s_q            <= s_d;
      idx_q          <= idx_d;
      samp_q         <= samp_d;
      shreg_q        <= shreg_d;
      perr_q         <= perr_d;
      fresh_q        <= fresh_d;
      rx_frame_q     <= rx_frame_d;
      rx_valid_q     <= rx_valid_d;
      rx_done_q      <= rx_done_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
      overrun_q      <= overrun_d;
    end
  end

  assign rx_frame     = rx_frame_q;
  assign rx_valid     = rx_valid_q;
  assign rx_done      = rx_done_q;
  assign parity_error = parity_error_q;
  assign frame_error  = frame_error_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - bench for uart_rx_os against a frame-level reference model
`timescale 1ns/1ps
module tb_uart_rx_os;

  localparam int BIT_CLK = 432;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic       rx_ready;
  logic [7:0] rx_frame;
  logic       rx_valid, rx_done, parity_error, frame_error, overrun;

  logic       uart_rx_odd;
  logic       rx_ready_odd;
  logic [7:0] odd_frame_o;
  logic       odd_valid, odd_done, odd_pe_o, odd_fe_o, odd_ov_o;

  uart_rx_os #(
    .CLK_FREQUENCE(50_000_000), .BAUD_RATE(115200), .PARITY("EVEN"),
    .FRAME_WD(8), .OVERSAMPLE(16)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .rx_ready(rx_ready),
    .rx_frame(rx_frame), .rx_valid(rx_valid), .rx_done(rx_done),
    .parity_error(parity_error), .frame_error(frame_error), .overrun(overrun)
  );

  uart_rx_os #(
    .CLK_FREQUENCE(50_000_000), .BAUD_RATE(115200), .PARITY("ODD"),
    .FRAME_WD(8), .OVERSAMPLE(16)
  ) dut_odd (
    .clk(clk), .rst(rst), .uart_rx(uart_rx_odd), .rx_ready(rx_ready_odd),
    .rx_frame(odd_frame_o), .rx_valid(odd_valid), .rx_done(odd_done),
    .parity_error(odd_pe_o), .frame_error(odd_fe_o), .overrun(odd_ov_o)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] frame;
    logic       pe;
    logic       fe;
    logic       ov;
  } rec_t;

  rec_t       rec_q[$];
  rec_t       mon_r;
  int         done_cnt = 0;
  int         ov_cnt   = 0;
  int         odd_cnt  = 0;
  int         odd_ov_cnt = 0;
  logic [7:0] odd_frame;
  logic       odd_pe, odd_fe;

  int         checks = 0;
  int         errors = 0;

  logic       valid_m;
  logic [7:0] frame_m;

  always @(negedge clk) begin
    if (rx_done) begin
      mon_r.frame = rx_frame;
      mon_r.pe    = parity_error;
      mon_r.fe    = frame_error;
      mon_r.ov    = overrun;
      rec_q.push_back(mon_r);
      done_cnt++;
    end
    if (overrun) ov_cnt++;
    if (odd_done) begin
      odd_cnt++;
      odd_frame = odd_frame_o;
      odd_pe    = odd_pe_o;
      odd_fe    = odd_fe_o;
    end
    if (odd_ov_o) odd_ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop_b,
                            input logic odd);
    logic        pbit;
    logic [10:0] bits;
    pbit = (odd ? ~(^d) : ^d) ^ flip;
    bits = {stop_b, pbit, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (odd) uart_rx_odd = bits[i];
      else     uart_rx     = bits[i];
      repeat (BIT_CLK) @(posedge clk);
    end
  endtask

  task automatic set_ready(input logic v);
    @(negedge clk);
    rx_ready = v;
    if (v) valid_m = 1'b0;
  endtask

  // Consumer-side model: a completed frame is taken unless an unread one blocks it.
  task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe,
                              input logic fe);
    rec_t r;
    logic ov;
    ov = valid_m && !rx_ready;
    if (!ov) begin
      frame_m = d;
      valid_m = 1'b1;
    end
    if (rx_ready) valid_m = 1'b0;
    check({tag, "_present"}, 32'(rec_q.size() > 0), 32'd1);
    if (rec_q.size() > 0) begin
      r = rec_q.pop_front();
      check({tag, "_frame"}, 32'(r.frame), 32'(frame_m));
      check({tag, "_perr"},  32'(r.pe),    32'(pe));
      check({tag, "_ferr"},  32'(r.fe),    32'(fe));
      check({tag, "_ovr"},   32'(r.ov),    32'(ov));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_frame"},  32'(rx_frame),     32'd0);
    check({tag, "_valid"},  32'(rx_valid),     32'd0);
    check({tag, "_done"},   32'(rx_done),      32'd0);
    check({tag, "_perr"},   32'(parity_error), 32'd0);
    check({tag, "_ferr"},   32'(frame_error),  32'd0);
    check({tag, "_ovr"},    32'(overrun),      32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rflip, rstop, rrdy;
    int         ov_base, done_base;

    rst          = 1'b1;
    uart_rx      = 1'b1;
    uart_rx_odd  = 1'b1;
    rx_ready     = 1'b0;
    rx_ready_odd = 1'b1;
    valid_m      = 1'b0;
    frame_m      = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (100) @(posedge clk);

    send_frame(8'h2B, 1'b0, 1'b1, 1'b0);
    expect_frame("nominal", 8'h2B, 1'b0, 1'b0);
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("nominal_valid_held", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    valid_m  = 1'b0;
    check("nominal_valid_clear", 32'(rx_valid), 32'd0);

    set_ready(1'b1);
    ov_base = ov_cnt;
    send_frame(8'h2B, 1'b0, 1'b1, 1'b0);
    send_frame(8'h35, 1'b0, 1'b1, 1'b0);
    expect_frame("b2b_a", 8'h2B, 1'b0, 1'b0);
    expect_frame("b2b_b", 8'h35, 1'b0, 1'b0);
    check("b2b_no_overrun", 32'(ov_cnt - ov_base), 32'd0);

    send_frame(8'h35, 1'b1, 1'b1, 1'b0);
    expect_frame("parity_fault", 8'h35, 1'b1, 1'b0);

    send_frame(8'h35, 1'b0, 1'b1, 1'b1);
    check("odd_done",  32'(odd_cnt),   32'd1);
    check("odd_frame", 32'(odd_frame), 32'h35);
    check("odd_perr",  32'(odd_pe),    32'd0);
    check("odd_ferr",  32'(odd_fe),    32'd0);

    done_base = done_cnt;
    send_frame(8'h2B, 1'b0, 1'b0, 1'b0);
    expect_frame("break", 8'h2B, 1'b0, 1'b1);
    repeat (5 * BIT_CLK) @(posedge clk);
    uart_rx = 1'b1;
    repeat (2 * BIT_CLK) @(posedge clk);
    check("break_single_done", 32'(done_cnt - done_base), 32'd1);

    for (int n = 0; n < 3; n++) begin
      rd    = 8'($urandom);
      rflip = ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 3) != 0);
      rrdy  = 1'($urandom_range(0, 1));
      set_ready(rrdy);
      send_frame(rd, rflip, rstop, 1'b0);
      expect_frame($sformatf("rand%0d", n), rd, rflip, !rstop);
      uart_rx = 1'b1;
      repeat (BIT_CLK) @(posedge clk);
    end
    set_ready(1'b1);
    repeat (4) @(posedge clk);

    set_ready(1'b0);
    done_base = done_cnt;
    @(negedge clk);
    uart_rx = 1'b0;
    #200;
    uart_rx = 1'b1;
    repeat (2 * BIT_CLK) @(posedge clk);
    check("glitch_no_done", 32'(done_cnt - done_base), 32'd0);

    ov_base = ov_cnt;
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    expect_frame("ovr_first",  8'h11, 1'b0, 1'b0);
    expect_frame("ovr_second", 8'h22, 1'b0, 1'b0);
    check("ovr_pulse_count", 32'(ov_cnt - ov_base), 32'd1);
    @(negedge clk);
    check("ovr_frame_kept", 32'(rx_frame), 32'h11);
    rx_ready = 1'b1;
    check("ovr_valid_before", 32'(rx_valid), 32'd1);
    @(negedge clk);
    check("ovr_valid_drop", 32'(rx_valid), 32'd0);
    rx_ready = 1'b0;
    valid_m  = 1'b0;

    done_base = done_cnt;
    fork
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    join_none
    repeat (4 * BIT_CLK + BIT_CLK / 2) @(posedge clk);
    #1;
    rst     = 1'b1;
    valid_m = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    repeat (7 * BIT_CLK) @(posedge clk);
    check("rst_mid_no_done", 32'(done_cnt - done_base), 32'd0);
    rst = 1'b0;
    repeat (50) @(posedge clk);
    set_ready(1'b1);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    expect_frame("after_rst", 8'h5A, 1'b0, 1'b0);
    check("odd_no_overrun", 32'(odd_ov_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
16x-oversampling UART receiver, the receive end of the team's UART link. It accepts the serial line driven by the frame transmitter (same CLK_FREQUENCE/BAUD_RATE/PARITY/FRAME_WD set) and recovers each frame. Each frame is presented on a valid/ready handshake, with parity, stop-bit and overrun status. It sits between the pad-side rx pin and the frame consumer; in loopback benches it pairs directly with the transmitter.

Parameters:
CLK_FREQUENCE, 50_000_000, system clock in Hz
BAUD_RATE, 115200, line rate in bit/s
PARITY, "EVEN", "NONE" | "EVEN" | "ODD"
FRAME_WD, 8, data bits per frame; 5..9 when PARITY="NONE", else 5..8
OVERSAMPLE, 16, samples per bit; tick divisor OS_DIV = round(CLK_FREQUENCE/(BAUD_RATE*OVERSAMPLE)), must be >= 2

Ports:
clk  in  1  system clock
rst  in  1  reset
uart_rx  in  1  asynchronous serial line, idle high
rx_ready  in  1  consumer accepts rx_frame when high with rx_valid
rx_frame  out  FRAME_WD  received data, LSB first on line
rx_valid  out  1  rx_frame holds an unconsumed frame
rx_done  out  1  one-cycle pulse per completed frame, good or bad
parity_error  out  1  parity mismatch on last frame; valid with rx_done, held until next rx_done
frame_error  out  1  stop bit sampled 0 on last frame; valid with rx_done, held until next rx_done
overrun  out  1  one-cycle pulse: frame completed while rx_valid still high

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high (ports clk, rst). All outputs 0 in reset; synchronizer flops reset to 1.
- uart_rx passes a 2-flop synchronizer; all logic uses the synchronized value rxs.
- Tick generator: counter 0..OS_DIV-1 emits os_tick. The counter is held at 0 in IDLE and restarts on start detection, so sampling phase aligns to the detected falling edge.
- FSM states: IDLE, START, DATA, PARITY, STOP. Sample counter s counts 0..OVERSAMPLE-1 per bit, advancing on os_tick.
- IDLE: on rxs 1->0, go to START with s=0.
- Bit decision: majority of 3 samples at s = OVERSAMPLE/2-1, /2, /2+1.
- START: at s=OVERSAMPLE-1, if the majority is 1 (glitch), return to IDLE with no outputs. Otherwise go to DATA with bit index 0.
- DATA: on each bit end, shift the majority into the frame register LSB-first. After FRAME_WD bits, go to PARITY if PARITY != "NONE", else STOP.
- PARITY: compare the majority bit with the computed parity. EVEN means data XOR = parity bit; ODD means data XOR = ~parity bit. A mismatch sets the internal perr flag.
- STOP: decide at s = OVERSAMPLE/2+1. Do not wait for the full stop bit, so back-to-back frames resynchronize.
  - Next clk: rx_done=1; parity_error=perr; frame_error=~stop_majority.
  - rx_frame is loaded and rx_valid set to 1 only if rx_valid==0 or rx_ready==1 that cycle. Otherwise rx_frame is kept, the new frame is dropped, and overrun pulses.
  - Return to IDLE. If rxs is already 0 there, treat it as a fresh start edge.
- Errored frames are still delivered, with the flags set.
- Handshake: rx_valid clears on the clk where rx_valid & rx_ready, unless a new frame loads in the same cycle (it stays 1 and rx_frame updates). rx_frame is stable while rx_valid=1 and not accepted.
- Latency: rx_done rises 2 sync cycles + 1 clk after the mid-stop-bit majority sample.
- A break (line held 0) yields one frame with frame_error=1, then waits in IDLE for rxs to return high before a new start edge is accepted.
- rst mid-frame aborts immediately. The first frame after release needs a clean falling edge.

Decomposition:
- Shared package uart_pkg:
  - PARITY encodings
  - parity function par(data, mode)
  - OS_DIV computation function
  - FSM state enum
- The transmitter reuses uart_pkg.
- One natural sub-module: uart_os_tick (tick divisor counter with sync clear), also usable by the transmitter for baud ticks.

Test Plan:
- Common setup: 50 MHz clk, 115200 baud, OS_DIV=27, bit time 432 clk.
- Nominal: send 0x2B, EVEN parity bit 0 -> rx_done once, rx_frame=0x2B, parity_error=0, frame_error=0, rx_valid=1 until rx_ready pulse.
- Back-to-back: 0x2B then 0x35 with a single stop bit, rx_ready tied 1 -> two rx_done pulses, frames 0x2B then 0x35, no overrun.
- Parity fault: 0x35 with parity bit forced 1 (EVEN) -> rx_done, rx_frame=0x35, parity_error=1, frame_error=0. Repeat with PARITY="ODD" and correct bit 1 -> no error.
- Stop fault / break: 0x2B with stop bit 0, then line held low 5 bit times -> exactly one rx_done with frame_error=1. No further rx_done until line high and a new edge.
- Glitch + overrun:
  - 200 ns low pulse on idle line -> no rx_done.
  - Then two frames 0x11, 0x22 with rx_ready=0 -> rx_frame stays 0x11, overrun pulses once at second rx_done.
  - Assert rx_ready -> rx_valid drops next clk.
- Reset mid-frame: assert rst during DATA bit 3 of 0xA5 -> all outputs 0 immediately. After release, next frame 0x5A is received correctly.
